// File: rtl/ysyx_041461_scoreboard_pkg.sv
// Shared scoreboard definitions: FSM encodings, counter ceiling and the untracked register index.
package ysyx_041461_scoreboard_pkg;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_DRAIN = 2'd1,
      SB_FLUSH = 2'd2
   } sb_state_e;

   localparam int unsigned SB_REG0 = 0;

   function automatic int unsigned sb_cnt_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/ysyx_041461_sb_cnt.sv
// Saturating pending-write counter with clear; flags zero, max and retire-without-pending.
module ysyx_041461_sb_cnt
   import ysyx_041461_scoreboard_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero,
   output logic             o_max,
   output logic             o_udf
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(sb_cnt_max(CNT_W));

   logic [CNT_W-1:0] r_cnt;

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);
   assign o_max  = (r_cnt == MAX);
   assign o_udf  = i_dec & o_zero & ~i_clr;

   // A decrement with nothing pending belongs to no allocation, so a same-cycle
   // increment still allocates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && !o_max) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_dec && !i_inc && !o_zero) begin
         r_cnt <= r_cnt - 1'b1;
      end else if (i_inc && i_dec && o_zero) begin
         r_cnt <= CNT_W'(1);
      end
   end

endmodule

// File: rtl/ysyx_041461_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gate issue; trap handling drains
// in-flight writes and then pulses a single flush.
module ysyx_041461_scoreboard
   import ysyx_041461_scoreboard_pkg::*;
#(
   parameter int unsigned NREG       = 32,
   parameter int unsigned RA_W       = 5,
   parameter int unsigned NSRC       = 2,
   parameter int unsigned CNT_W      = 2,
   parameter int unsigned INF_W      = 4,
   parameter int unsigned RET_BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_valid,
   output logic                 iss_ready,
   input  logic [NSRC-1:0]      iss_rs_en,
   input  logic [NSRC*RA_W-1:0] iss_rs,
   input  logic                 iss_rd_en,
   input  logic [RA_W-1:0]      iss_rd,
   input  logic                 iss_csr_rd,
   input  logic                 iss_csr_wr,
   input  logic                 ret_valid,
   input  logic                 ret_rd_en,
   input  logic [RA_W-1:0]      ret_rd,
   input  logic                 ret_csr_wr,
   input  logic                 trap_req,
   output logic                 trap_ack,
   output logic                 busy,
   output logic                 sb_err
);

   sb_state_e r_state;
   logic      r_ack;
   logic      r_err;

   logic             w_fire;
   logic             w_clr;
   logic             w_iss_trk;
   logic             w_ret_trk;
   logic             w_hazard;
   logic [NREG-1:0]  w_max;
   logic [NREG-1:0]  w_udf;
   logic [NREG-1:0]  w_eff_nz;
   logic [CNT_W-1:0] w_csr_cnt;
   logic             w_csr_dec;
   logic             w_csr_zero;
   logic             w_csr_max;
   logic             w_csr_udf;
   logic             w_csr_eff_nz;
   logic [INF_W-1:0] w_inf_cnt;
   logic             w_inf_zero;
   logic             w_inf_max;
   logic             w_inf_udf;

   assign w_fire    = iss_valid & iss_ready;
   assign w_clr     = (r_state == SB_FLUSH);
   assign w_iss_trk = w_fire & ((iss_rd_en & (iss_rd != RA_W'(SB_REG0))) | iss_csr_wr);
   assign w_ret_trk = ret_valid & ((ret_rd_en & (ret_rd != RA_W'(SB_REG0))) | ret_csr_wr);
   assign w_csr_dec = ret_valid & ret_csr_wr;

   assign w_max[0]    = 1'b0;
   assign w_udf[0]    = 1'b0;
   assign w_eff_nz[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_reg
      logic             w_inc;
      logic             w_dec;
      logic             w_zero;
      logic [CNT_W-1:0] w_cnt;

      assign w_inc = w_fire & iss_rd_en & (iss_rd == RA_W'(g));
      assign w_dec = ret_valid & ret_rd_en & (ret_rd == RA_W'(g));

      ysyx_041461_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_inc  (w_inc),
         .i_dec  (w_dec),
         .i_clr  (w_clr),
         .o_cnt  (w_cnt),
         .o_zero (w_zero),
         .o_max  (w_max[g]),
         .o_udf  (w_udf[g])
      );

      // The last pending write retiring this cycle no longer blocks a reader.
      assign w_eff_nz[g] = ~w_zero &
                           ~((RET_BYPASS != 0) & w_dec & (w_cnt == CNT_W'(1)));
   end

   ysyx_041461_sb_cnt #(.CNT_W(CNT_W)) u_csr_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (w_fire & iss_csr_wr),
      .i_dec  (w_csr_dec),
      .i_clr  (w_clr),
      .o_cnt  (w_csr_cnt),
      .o_zero (w_csr_zero),
      .o_max  (w_csr_max),
      .o_udf  (w_csr_udf)
   );

   assign w_csr_eff_nz = ~w_csr_zero &
                         ~((RET_BYPASS != 0) & w_csr_dec & (w_csr_cnt == CNT_W'(1)));

   ysyx_041461_sb_cnt #(.CNT_W(INF_W)) u_inflight (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (w_iss_trk),
      .i_dec  (w_ret_trk),
      .i_clr  (w_clr),
      .o_cnt  (w_inf_cnt),
      .o_zero (w_inf_zero),
      .o_max  (w_inf_max),
      .o_udf  (w_inf_udf)
   );

   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (iss_rs_en[i] && w_eff_nz[iss_rs[i*RA_W +: RA_W]]) w_hazard = 1'b1;
      end
      if (iss_rd_en && w_max[iss_rd])        w_hazard = 1'b1;
      if (iss_csr_rd && w_csr_eff_nz)        w_hazard = 1'b1;
      if (iss_csr_wr && w_csr_max)           w_hazard = 1'b1;
      if (w_inf_max)                         w_hazard = 1'b1;
      if (r_state != SB_IDLE || trap_req)    w_hazard = 1'b1;
   end

   assign iss_ready = rst_n & ~w_hazard;
   assign busy      = (w_inf_cnt != '0);
   assign trap_ack  = r_ack;
   assign sb_err    = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SB_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if ((|w_udf) || w_csr_udf || w_inf_udf) r_err <= 1'b1;
         case (r_state)
            SB_IDLE: begin
               r_ack <= 1'b0;
               if (trap_req) r_state <= SB_DRAIN;
            end
            SB_DRAIN: begin
               if (w_inf_zero) begin
                  r_state <= SB_FLUSH;
                  r_ack   <= 1'b1;
               end
            end
            SB_FLUSH: begin
               r_state <= SB_IDLE;
               r_ack   <= 1'b0;
            end
            default: begin
               r_state <= SB_IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ysyx_041461_scoreboard.md
Name: ysyx_041461_scoreboard

Overview:
- Parametrised, stateful successor to the pipeline conflict detector.
- Tracks in-flight GPR and CSR writes with per-register pending-write counters instead of comparing fixed stage rd fields, so pipeline depth and the number of source operands are free.
- Gates instruction issue (RAW/WAW/CSR hazards) and sequences trap handling: it blocks issue, drains older in-flight writes, then emits a single flush pulse.
- Sits between the ID stage (issue) and the WB stage (retire).

Parameters:
- NREG, 32, number of architectural GPRs; reg 0 is never tracked.
- RA_W, 5, register index width (log2 NREG).
- NSRC, 2, source operands checked per issue.
- CNT_W, 2, width of each pending-write counter (max outstanding = 2^CNT_W-1).
- INF_W, 4, width of the total in-flight counter.
- RET_BYPASS, 1, when 1 a same-cycle retire clears a hazard.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- iss_valid  in  1  ID has an instruction to issue
- iss_ready  out  1  issue permitted this cycle
- iss_rs_en  in  NSRC  per-source read enable
- iss_rs  in  NSRC*RA_W  packed source indices
- iss_rd_en  in  1  instruction writes rd
- iss_rd  in  RA_W  destination index
- iss_csr_rd  in  1  instruction reads a CSR
- iss_csr_wr  in  1  instruction writes a CSR
- ret_valid  in  1  WB retires (or squashes) a tracked instruction
- ret_rd_en  in  1  retiring instruction had rd write
- ret_rd  in  RA_W  its rd
- ret_csr_wr  in  1  retiring instruction had CSR write
- trap_req  in  1  trap detected in any stage (level, held until trap_ack)
- trap_ack  out  1  one-cycle pulse: drain complete, pipeline flush
- busy  out  1  any write in flight
- sb_err  out  1  sticky underflow/overflow error

Interface note: one clock; reset is asynchronous and active-low; all state clears on rst_n low, independent of clk.

Behaviour:
- Reset values: all counters 0, state IDLE, iss_ready=0 while rst_n low, trap_ack=0, busy=0, sb_err=0.
- State: cnt[1..NREG-1] (CNT_W bits), csr_cnt (CNT_W), inflight (INF_W).
- Fire: iss_fire = iss_valid & iss_ready.
  - On fire, cnt[iss_rd]++ if iss_rd_en and iss_rd!=0; csr_cnt++ if iss_csr_wr.
  - inflight++ if either write is tracked.
- Retire: on ret_valid, decrement the matching counters and inflight.
  - Same-cycle fire and retire on the same counter: net 0.
- Hazard. iss_ready=0 if any of:
  - RAW: iss_rs_en[i] & rs[i]!=0 & eff_cnt[rs[i]]!=0.
  - WAW overflow: iss_rd_en & cnt[iss_rd]==max.
  - CSR: iss_csr_rd & eff_csr!=0.
  - CSR overflow: iss_csr_wr & csr_cnt==max.
  - inflight==max.
  - state!=IDLE.
- eff_cnt:
  - RET_BYPASS=1: cnt minus a same-cycle retire hitting that register.
  - RET_BYPASS=0: registered cnt.
- iss_ready is combinational from registered state plus current-cycle inputs. No internal latency beyond that.
- FSM:
  - IDLE: trap_req -> DRAIN. Issue is blocked from the same cycle trap_req rises.
  - DRAIN: wait for inflight==0, counting retire-path updates. Then -> FLUSH.
  - FLUSH: trap_ack=1 for exactly one cycle. All counters forced to 0 (defensive). -> IDLE.
  - trap_req must drop by the cycle after trap_ack. A still-high trap_req in IDLE re-enters DRAIN.
- Boundaries:
  - Retire with a zero counter: counter stays 0, sb_err set.
  - Fire while a counter is at max cannot occur, because ready is low.
  - Reset mid-DRAIN: immediate return to IDLE with no trap_ack.
  - iss_rd==0 never allocates.
  - An rs equal to the issuing rd in the same cycle checks only prior state.
- busy = (inflight!=0).

Decomposition:
- Shared macro file: state encodings (SB_IDLE/SB_DRAIN/SB_FLUSH), CNT max constant, reg-0 index.
- Sub-module ysyx_041461_sb_cnt: one saturating up/down counter with inc/dec/clr inputs, a zero flag and an underflow flag. Instantiated NREG-1 times plus once for CSR.

Test Plan:
- Issue `addi x5` (rd=5), then next cycle issue a read of rs1=5 with no retire -> iss_ready=0. Retire rd=5 -> with RET_BYPASS=1, ready=1 in the same cycle.
- Issue three writes to x7 (CNT_W=2) with no retires -> third fire accepted, cnt[7]=3; a fourth write to x7 -> iss_ready=0 until one retire.
- CSR write in flight (csr_cnt=1), then issue iss_csr_rd -> ready=0. Issue to a GPR-only reader of x0 -> ready=1.
- Two writes in flight, assert trap_req -> ready=0 immediately. After two retires, trap_ack pulses exactly one cycle, then state IDLE, busy=0.
- ret_valid rd=9 with cnt[9]=0 -> sb_err=1 and stays 1; cnt[9] stays 0.
- Assert rst_n=0 during DRAIN with inflight=3 -> all outputs at reset values asynchronously; no trap_ack after release.
